// File: rtl/ctrl_unit_pipe_if.sv
// ctrl_unit_pipe_if: IF/ID-side inputs and ID/EX-side outputs of ctrl_unit_pipe.
// illegal_out exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface ctrl_unit_pipe_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
);
  logic [31:0]           instr;
  logic                  instr_valid;
  logic                  stall_in;
  logic                  flush;
  logic                  stall_req;
  logic                  valid_out;
  logic [ALU_OP_W+1:0]   ex_ctrl;
  logic [3:0]            mem_ctrl;
  logic [1:0]            wb_ctrl;
  logic [XLEN-1:0]       imm;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [2:0]            funct3;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                  illegal_out;
`endif

  modport master (
    output instr, instr_valid, stall_in, flush,
    input  stall_req, valid_out, ex_ctrl, mem_ctrl, wb_ctrl, imm, rd, rs1, rs2, funct3
`ifdef CTRL_ILLEGAL_TRAP_EN
    , illegal_out
`endif
  );

  modport slave (
    input  instr, instr_valid, stall_in, flush,
    output stall_req, valid_out, ex_ctrl, mem_ctrl, wb_ctrl, imm, rd, rs1, rs2, funct3
`ifdef CTRL_ILLEGAL_TRAP_EN
    , illegal_out
`endif
  );
endinterface

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: registered ID/EX decode with load-use interlock, flush bubbles
// and downstream stall hold. Define CTRL_ILLEGAL_TRAP_EN to add illegal_out.
module ctrl_unit_pipe #(
  parameter int XLEN        = 64,
  parameter int REG_ADDR_W  = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int ALU_OP_W    = 4
) (
  input logic             clk,
  input logic             rst,
  ctrl_unit_pipe_if.slave bus
);
  localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_SD   = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_R    = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic                  valid;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                  illegal;
`endif
    logic [ALU_OP_W+1:0]   ex;
    logic [3:0]            mem;
    logic [1:0]            wb;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [2:0]            funct3;
  } slot_t;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic slot_t decode(input logic [31:0] ins);
    slot_t               s;
    logic                known;
    logic                alu_src;
    logic                reg_write;
    logic                mem_to_reg;
    logic [3:0]          mem;
    logic [ALU_OP_W-1:0] alu_op;
    logic signed [31:0]  raw;
    s          = '0;
    known      = 1'b1;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem        = 4'b0000;
    alu_op     = '0;
    raw        = '0;
    case (ins[6:2])
      OP_LD: begin
        raw = {{20{ins[31]}}, ins[31:20]};
        alu_src = 1'b1; mem = 4'b0010; mem_to_reg = 1'b1; reg_write = 1'b1;
      end
      OP_SD: begin
        raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        alu_src = 1'b1; mem = 4'b0001;
      end
      OP_ADDI: begin
        raw = {{20{ins[31]}}, ins[31:20]};
        alu_src = 1'b1; reg_write = 1'b1;
      end
      OP_R: begin
        alu_op = ALU_OP_W'({ins[30], ins[14:12]});
        reg_write = 1'b1;
      end
      OP_BR: begin
        raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        alu_op = ALU_OP_W'(4'b1000); mem = 4'b0100;
      end
      OP_JAL: begin
        raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        mem = 4'b1000; reg_write = 1'b1;
      end
      OP_JALR: begin
        raw = {{20{ins[31]}}, ins[31:20]};
        alu_src = 1'b1; mem = 4'b1000; reg_write = 1'b1;
      end
      default: known = 1'b0;
    endcase
    if (known) begin
      s.valid  = 1'b1;
      s.ex     = {alu_src, alu_op, reg_write};
      s.mem    = mem;
      s.wb     = {mem_to_reg, reg_write};
      s.imm    = sext32(raw);
      s.rd     = REG_ADDR_W'(ins[11:7]);
      s.rs1    = REG_ADDR_W'(ins[19:15]);
      s.rs2    = REG_ADDR_W'(ins[24:20]);
      s.funct3 = ins[14:12];
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      s.valid   = 1'b1;
      s.illegal = 1'b1;
`endif
    end
    return s;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  slot_t                 slot_q, slot_d;
  slot_t                 dec;
  logic                  reads_rs1, reads_rs2;
  logic                  stall_req;
  logic [REG_ADDR_W-1:0] rs1_in, rs2_in;
  logic                  unused_low;

  assign unused_low = ^bus.instr[1:0];
  assign dec        = decode(bus.instr);
  assign rs1_in     = REG_ADDR_W'(bus.instr[19:15]);
  assign rs2_in     = REG_ADDR_W'(bus.instr[24:20]);

  // Source operands the incoming instruction actually reads
  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    case (bus.instr[6:2])
      OP_LD, OP_ADDI, OP_JALR: reads_rs1 = 1'b1;
      OP_SD, OP_R, OP_BR: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- state register / ID/EX boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  // Flush always reloads; FLUSH runs down regardless of stall_in
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
      state_d = (FLUSH_DEPTH > 1) ? S_FLUSH : S_RUN;
    end else if (state_q == S_FLUSH) begin
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = (cnt_q == CNT_W'(1)) ? S_RUN : S_FLUSH;
    end
  end

  always_comb begin
    stall_req = !rst && !bus.flush && !bus.stall_in && (state_q == S_RUN) &&
                bus.instr_valid && slot_q.valid && slot_q.mem[1] &&
                (slot_q.rd != '0) &&
                ((reads_rs1 && (rs1_in == slot_q.rd)) ||
                 (reads_rs2 && (rs2_in == slot_q.rd)));
    slot_d = slot_q;
    if (bus.flush || (state_q == S_FLUSH)) begin
      slot_d = '0;
    end else if (bus.stall_in) begin
      slot_d = slot_q;
    end else if (stall_req || !bus.instr_valid) begin
      slot_d = '0;
    end else begin
      slot_d = dec;
    end
  end

  assign bus.stall_req = stall_req;
  assign bus.valid_out = slot_q.valid;
  assign bus.ex_ctrl   = slot_q.ex;
  assign bus.mem_ctrl  = slot_q.mem;
  assign bus.wb_ctrl   = slot_q.wb;
  assign bus.imm       = slot_q.imm;
  assign bus.rd        = slot_q.rd;
  assign bus.rs1       = slot_q.rs1;
  assign bus.rs2       = slot_q.rs2;
  assign bus.funct3    = slot_q.funct3;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_out = slot_q.illegal;
`endif
endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb_ctrl_unit_pipe: vector table, hand sequences for interlock/flush/stall,
// and randomized traffic against a behavioural model.
module tb_ctrl_unit_pipe;
  localparam int XLEN = 64;
  localparam int RAW  = 5;
  localparam int FD   = 2;
  localparam int AOW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_unit_pipe_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .ALU_OP_W(AOW)) bus ();
  ctrl_unit_pipe #(.XLEN(XLEN), .REG_ADDR_W(RAW), .FLUSH_DEPTH(FD), .ALU_OP_W(AOW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        valid;
    logic        illegal;
    logic [5:0]  ex;
    logic [3:0]  mem;
    logic [1:0]  wb;
    logic [63:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t z;
  vec_t vt[10];

  function automatic exp_t mk(input logic v, input logic [5:0] ex, input logic [3:0] mem,
                              input logic [1:0] wb, input logic [63:0] imm, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
    exp_t e;
    e.valid = v; e.illegal = 1'b0; e.ex = ex; e.mem = mem; e.wb = wb;
    e.imm = imm; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3;
    return e;
  endfunction

  // Reference decode straight from the opcode table
  function automatic exp_t mdecode(input logic [31:0] i);
    exp_t e;
    e = mk(1'b1, 6'h0, 4'h0, 2'b0, 64'h0, i[11:7], i[19:15], i[24:20], i[14:12]);
    case (i[6:2])
      5'b00000: begin e.ex = 6'b100001; e.mem = 4'b0010; e.wb = 2'b11;
                      e.imm = longint'($signed(i[31:20])); end
      5'b01000: begin e.ex = 6'b100000; e.mem = 4'b0001;
                      e.imm = longint'($signed({i[31:25], i[11:7]})); end
      5'b00100: begin e.ex = 6'b100001; e.wb = 2'b01;
                      e.imm = longint'($signed(i[31:20])); end
      5'b01100: begin e.ex = {1'b0, i[30], i[14:12], 1'b1}; e.wb = 2'b01; end
      5'b11000: begin e.ex = 6'b010000; e.mem = 4'b0100;
                      e.imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      5'b11011: begin e.ex = 6'b000001; e.mem = 4'b1000; e.wb = 2'b01;
                      e.imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      5'b11001: begin e.ex = 6'b100001; e.mem = 4'b1000; e.wb = 2'b01;
                      e.imm = longint'($signed(i[31:20])); end
      default: begin
        e = z;
`ifdef CTRL_ILLEGAL_TRAP_EN
        e.valid = 1'b1; e.illegal = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  function automatic bit mreads(input logic [31:0] i, input logic [4:0] r);
    bit r1, r2;
    r1 = (i[6:2] inside {5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b11000, 5'b11001});
    r2 = (i[6:2] inside {5'b01100, 5'b01000, 5'b11000});
    return (r1 && i[19:15] == r) || (r2 && i[24:20] == r);
  endfunction

  function automatic logic [31:0] gen();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] im;
    logic [31:0] r;
    rd = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    im = 12'($urandom); r = $urandom;
    case ($urandom_range(0, 7))
      0: return {im, rs1, 3'b011, rd, 7'b0000011};
      1: return {im[11:5], rs2, rs1, 3'b011, im[4:0], 7'b0100011};
      2: return {im, rs1, 3'b000, rd, 7'b0010011};
      3: return {1'b0, r[0], 5'b0, rs2, rs1, r[3:1], rd, 7'b0110011};
      4: return {r[31:25], rs2, rs1, 3'b001, r[11:7], 7'b1100011};
      5: return {r[31:12], rd, 7'b1101111};
      6: return {im, rs1, 3'b000, rd, 7'b1100111};
      default: return r;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_slot(input string tag, input exp_t e);
    check($sformatf("%s.valid", tag), 64'(bus.valid_out), 64'(e.valid));
    check($sformatf("%s.ex", tag),    64'(bus.ex_ctrl),   64'(e.ex));
    check($sformatf("%s.mem", tag),   64'(bus.mem_ctrl),  64'(e.mem));
    check($sformatf("%s.wb", tag),    64'(bus.wb_ctrl),   64'(e.wb));
    check($sformatf("%s.imm", tag),   bus.imm,            e.imm);
    check($sformatf("%s.rd", tag),    64'(bus.rd),        64'(e.rd));
    check($sformatf("%s.rs1", tag),   64'(bus.rs1),       64'(e.rs1));
    check($sformatf("%s.rs2", tag),   64'(bus.rs2),       64'(e.rs2));
    check($sformatf("%s.funct3", tag), 64'(bus.funct3),   64'(e.f3));
`ifdef CTRL_ILLEGAL_TRAP_EN
    check($sformatf("%s.illegal", tag), 64'(bus.illegal_out), 64'(e.illegal));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ld_e, add_e, addi_e, m_out;
    int   m_left;
    bit   exp_stall, prev_stall;
    z = mk(1'b0, 6'h0, 4'h0, 2'b0, 64'h0, 5'd0, 5'd0, 5'd0, 3'd0);

    vt[0] = '{32'h00500093, mk(1'b1, 6'h21, 4'h0, 2'd1, 64'd5, 5'd1, 5'd0, 5'd5, 3'd0)};
    vt[1] = '{32'h401101B3, mk(1'b1, 6'h11, 4'h0, 2'd1, 64'd0, 5'd3, 5'd2, 5'd1, 3'd0)};
    vt[2] = '{32'h0080B103, mk(1'b1, 6'h21, 4'h2, 2'd3, 64'd8, 5'd2, 5'd1, 5'd8, 3'd3)};
    vt[3] = '{32'hFE000EE3, mk(1'b1, 6'h10, 4'h4, 2'd0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 5'd0, 5'd0, 3'd0)};
    vt[4] = '{32'h00513823, mk(1'b1, 6'h20, 4'h1, 2'd0, 64'd16, 5'd16, 5'd2, 5'd5, 3'd3)};
    vt[5] = '{32'hFF9FF0EF, mk(1'b1, 6'h01, 4'h8, 2'd1, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 5'd31, 5'd25, 3'd7)};
    vt[6] = '{32'h00008067, mk(1'b1, 6'h21, 4'h8, 2'd1, 64'd0, 5'd0, 5'd1, 5'd0, 3'd0)};
    vt[7] = '{32'h007372B3, mk(1'b1, 6'h0F, 4'h0, 2'd1, 64'd0, 5'd5, 5'd6, 5'd7, 3'd7)};
    vt[8] = '{32'hFFF50513, mk(1'b1, 6'h21, 4'h0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 5'd10, 5'd31, 3'd0)};
`ifdef CTRL_ILLEGAL_TRAP_EN
    vt[9] = '{32'h0000007F, z};
    vt[9].e.valid = 1'b1;
    vt[9].e.illegal = 1'b1;
`else
    vt[9] = '{32'h0000007F, z};
`endif
    ld_e   = vt[2].e;
    addi_e = vt[0].e;
    add_e  = mk(1'b1, 6'h01, 4'h0, 2'd1, 64'd0, 5'd3, 5'd2, 5'd1, 3'd0);

    // Reset held two cycles with a live ADDI on the input
    rst = 1'b1; bus.instr = 32'h00500093; bus.instr_valid = 1'b1;
    bus.stall_in = 1'b0; bus.flush = 1'b0;
    repeat (2) begin
      tick();
      check_slot("reset", z);
      check("reset.stall_req", 64'(bus.stall_req), 64'd0);
    end
    rst = 1'b0;
    tick();
    check_slot("post_reset", addi_e);

    foreach (vt[k]) begin
      bus.instr_valid = 1'b0;
      tick();
      bus.instr = vt[k].instr; bus.instr_valid = 1'b1;
      tick();
      check_slot($sformatf("vec%0d", k), vt[k].e);
    end

    // Load-use: LD x2 then ADD reading x2, held upstream while stalled
    bus.instr_valid = 1'b0; tick();
    bus.instr = 32'h0080B103; bus.instr_valid = 1'b1; tick();
    check_slot("lu.ld", ld_e);
    bus.instr = 32'h001101B3; #1;
    check("lu.stall_req1", 64'(bus.stall_req), 64'd1);
    tick();
    check_slot("lu.bubble", z);
    check("lu.stall_req2", 64'(bus.stall_req), 64'd0);
    tick();
    check_slot("lu.add", add_e);

    // BEQ then a one-cycle flush: two bubbles, then decode resumes
    bus.instr = 32'hFE000EE3; tick();
    check_slot("br.beq", vt[3].e);
    bus.instr = 32'h00500093; bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    check_slot("fl.bubble1", z);
    tick();
    check_slot("fl.bubble2", z);
    tick();
    check_slot("fl.resume", addi_e);

    // Downstream stall freezes LD and suppresses the interlock; flush overrides
    bus.instr = 32'h0080B103; tick();
    check_slot("st.ld", ld_e);
    bus.instr = 32'h001101B3; bus.stall_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("st.stall_req%0d", c), 64'(bus.stall_req), 64'd0);
      tick();
      check_slot($sformatf("st.hold%0d", c), ld_e);
    end
    bus.flush = 1'b1; tick();
    check_slot("st.flush", z);
    bus.flush = 1'b0; bus.stall_in = 1'b0; tick();
    check_slot("st.flush2", z);
    tick();
    check_slot("st.add", add_e);

    // Randomized traffic against the behavioural model
    rst = 1'b1; tick(); rst = 1'b0;
    m_out = z; m_left = 0; prev_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!prev_stall) begin
        bus.instr = gen();
        bus.instr_valid = ($urandom_range(0, 9) != 0);
      end
      bus.flush    = ($urandom_range(0, 19) == 0);
      bus.stall_in = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 299) == 0);
      #1;
      exp_stall = !rst && !bus.flush && !bus.stall_in && (m_left == 0) && bus.instr_valid &&
                  m_out.valid && m_out.mem[1] && (m_out.rd != 5'd0) && mreads(bus.instr, m_out.rd);
      check("rnd.stall_req", 64'(bus.stall_req), 64'(exp_stall));
      if (rst) begin
        m_out = z; m_left = 0;
      end else if (bus.flush) begin
        m_out = z; m_left = FD - 1;
      end else if (m_left > 0) begin
        m_out = z; m_left--;
      end else if (!bus.stall_in) begin
        m_out = (exp_stall || !bus.instr_valid) ? z : mdecode(bus.instr);
      end
      tick();
      check_slot("rnd", m_out);
      prev_stall = exp_stall;
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_unit_pipe.md
Name: ctrl_unit_pipe

Overview:
Parametrised successor to the combinational decode/control unit of the five-stage pipeline. It decodes the IF/ID instruction and registers the EX/MEM/WB control bundles, register addresses and a sign-extended immediate into the ID/EX boundary. It adds three things the combinational unit lacks: load-use hazard interlock, branch/jump flush sequencing, and downstream stall hold.

Parameters:
XLEN, 64, width of the sign-extended immediate output.
REG_ADDR_W, 5, register address width; rd/rs1/rs2 are taken from their standard fields, zero-extended if REG_ADDR_W exceeds 5.
FLUSH_DEPTH, 2, number of consecutive output bubbles after a flush request (minimum 1).
ALU_OP_W, 4, ALU opcode width (minimum 4); upper bits are zero-padded.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
instr  in  32  instruction from IF/ID
instr_valid  in  1  instr holds a real instruction
stall_in  in  1  downstream stall; hold all registered outputs
flush  in  1  taken branch/jump resolved in MEM
stall_req  out  1  combinational load-use stall request to PC and IF/ID
valid_out  out  1  registered; ID/EX slot holds a real instruction
ex_ctrl  out  ALU_OP_W+2  registered {ALUSrc, ALU_OP, RegDst}
mem_ctrl  out  4  registered {Jump, Branch, MemRead, MemWrite}
wb_ctrl  out  2  registered {MemtoReg, RegWrite}
imm  out  XLEN  registered sign-extended immediate
rd, rs1, rs2  out  REG_ADDR_W each  registered register addresses
funct3  out  3  registered instr[14:12], used by the branch comparator

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset, every registered output is 0, the state is RUN and flush_cnt is 0. A reset asserted mid-flush or mid-stall aborts that activity.
- Latency: 1 cycle from instr to the registered outputs.
- A bubble means valid_out=0, all ctrl bits 0, imm=0 and rd/rs1/rs2=0.
- Decode on opcode instr[6:2]:
  - 00000 LD: I-imm; ALUSrc=1, ALU add (0); MemRead=1; MemtoReg=1; RegWrite=1.
  - 01000 SD: S-imm {31:25,11:7}; ALUSrc=1, ALU add; MemWrite=1.
  - 00100 ADDI: I-imm; ALUSrc=1, ALU add; RegWrite=1.
  - 01100 R-type: imm=0; ALUSrc=0; ALU_OP={instr[30],funct3}; RegWrite=1.
  - 11000 BEQ/BNE: B-imm {31,7,30:25,11:8,0}; ALUSrc=0; ALU_OP=1000 (sub); Branch=1.
  - 11011 JAL: J-imm {31,19:12,20,30:21,0}; Jump=1; RegWrite=1 (link).
  - 11001 JALR: I-imm; ALUSrc=1, ALU add; Jump=1; RegWrite=1.
  - Any other opcode decodes to a bubble.
- All immediates are sign-extended from their MSB to XLEN. RegDst=1 whenever RegWrite=1. A write to rd=0 keeps RegWrite as decoded.
- Load-use check: stall_req=1 when all of the following hold:
  - valid_out=1, mem_ctrl.MemRead=1 and rd!=0;
  - instr_valid=1, state=RUN, flush=0;
  - the incoming instruction reads rd. rs1 counts for every type except JAL. rs2 counts only for R-type, SD and branches.
- While stall_req=1, a bubble is registered next cycle. Upstream holds instr, which is re-decoded the following cycle and then passes.
- Priority each cycle: rst > flush > stall_in > load-use > normal decode.
- stall_in=1 with no flush: all outputs hold, stall_req is forced to 0, and no state change occurs.
- FSM:
  - RUN: flush=1 registers a bubble, loads flush_cnt=FLUSH_DEPTH-1, and moves to FLUSH if that value is nonzero.
  - FLUSH: registers a bubble each cycle, ignoring instr, and decrements flush_cnt. It returns to RUN when flush_cnt=0 at the clock edge.
  - flush asserted again while in FLUSH reloads flush_cnt.
  - stall_in does not freeze flush_cnt. Flush takes priority.
- instr_valid=0 in RUN registers a bubble.

Optional Feature:
Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: adds output illegal_out (1 bit, registered, reset 0). It is set for one valid slot when an unknown opcode arrives with instr_valid=1 in RUN. In that case valid_out=1 and all ctrl bits are 0. It obeys stall_in hold and flush, and is cleared by a bubble.
- Undefined: the port is absent and an unknown opcode yields a plain bubble (valid_out=0).

Test Plan:
- Reset: rst=1 for 2 cycles with instr=0x00500093 → all outputs 0, stall_req=0; the first cycle after release shows ADDI.
- ADDI then SUB: 0x00500093 (ADDI x1,x0,5) → imm=5, rd=1, ex_ctrl ALUSrc=1, wb_ctrl=01. Next 0x401101B3 (SUB x3,x2,x1) → ALU_OP=1000, ALUSrc=0, rs1=2, rs2=1.
- Load-use: 0x0080B103 (LD x2,8(x1)) then 0x001101B3 (ADD x3,x2,x1) held by upstream → stall_req=1 for exactly 1 cycle. The ID/EX slot gets a bubble, then ADD with valid_out=1.
- BEQ sign extension: 0xFE000EE3 (BEQ x0,x0,-4) → imm=0xFFFF_FFFF_FFFF_FFFC, Branch=1. With FLUSH_DEPTH=2, a flush pulse → 2 bubbles, then normal decode resumes.
- Downstream stall: stall_in=1 for 3 cycles after LD is registered → outputs frozen, stall_req=0. A flush during the stall_in window overrides the hold and produces a bubble.
- Unknown opcode 0x0000007F: without the macro → bubble. With CTRL_ILLEGAL_TRAP_EN → illegal_out=1 and valid_out=1 for one cycle.
